// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and FSM-state definitions for the multicycle ALU.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_NAND = 4'd2,
      OP_XOR  = 4'd3,
      OP_INC  = 4'd4,
      OP_SRA  = 4'd5,
      OP_SRL  = 4'd6,
      OP_SLL  = 4'd7,
      OP_MUL  = 4'd8
   } alu_op_e;

   localparam int unsigned FLG_Z = 2;
   localparam int unsigned FLG_V = 1;
   localparam int unsigned FLG_N = 0;

   typedef enum logic {
      IDLE = 1'b0,
      EXEC = 1'b1
   } alu_state_e;

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative engine for shifts (one bit per step) and shift-add multiply
// (one multiplier bit per step); flags the final step with a registered last.
module alu_iter_unit import alu_pkg::*; #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             step,
   input  alu_op_e          op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [SHW-1:0]   shamt,
   output logic [WIDTH-1:0] value_c,
   output logic             last
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   alu_op_e          kind;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [CW-1:0]    count;
   logic [CW-1:0]    count_init;

   always_comb count_init = (op == OP_MUL) ? CW'(WIDTH) : CW'(shamt);

   // last is registered one step ahead so the top sees it on the final step
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         kind   <= OP_ADD;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         count  <= '0;
         last   <= 1'b0;
      end else if (load) begin
         kind   <= op;
         acc    <= (op == OP_MUL) ? '0 : a;
         mcand  <= a;
         mplier <= b;
         count  <= count_init;
         last   <= (count_init == CW'(1));
      end else if (step) begin
         acc    <= value_c;
         mcand  <= {mcand[WIDTH-2:0], 1'b0};
         mplier <= {1'b0, mplier[WIDTH-1:1]};
         count  <= count - CW'(1);
         last   <= (count == CW'(2));
      end
   end

   always_comb begin
      value_c = acc;
      case (kind)
         OP_SRA:  value_c = {acc[WIDTH-1], acc[WIDTH-1:1]};
         OP_SRL:  value_c = {1'b0, acc[WIDTH-1:1]};
         OP_SLL:  value_c = {acc[WIDTH-2:0], 1'b0};
         OP_MUL:  if (mplier[0]) value_c = acc + mcand;
         default: value_c = acc;
      endcase
   end

endmodule

// File: rtl/multicycle_alu.sv
// Registered EX-stage ALU: single-cycle arithmetic/logic on accept, iterative
// shifts and multiply through alu_iter_unit, start/busy/done handshake.
module multicycle_alu import alu_pkg::*; #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned SHW    = $clog2(WIDTH),
   parameter bit          SAT_EN = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [SHW-1:0]   shamt,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [2:0]       flags
);

   localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

   alu_state_e       state, state_next;
   alu_op_e          op_in;
   logic             mul_q, mul_next;
   logic             busy_next, done_next;
   logic [WIDTH-1:0] result_next;
   logic [2:0]       flags_next;
   logic [WIDTH-1:0] addend, sum, sc_result;
   logic [2:0]       sc_flags;
   logic             ovf;
   logic             load, step, last;
   logic [WIDTH-1:0] iter_value;

   assign op_in = alu_op_e'(op);

   alu_iter_unit #(.WIDTH(WIDTH), .SHW(SHW)) u_iter (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .step    (step),
      .op      (op_in),
      .a       (a),
      .b       (b),
      .shamt   (shamt),
      .value_c (iter_value),
      .last    (last)
   );

   // Single-cycle datapath; flags default to the held register (illegal ops)
   always_comb begin
      addend    = (op_in == OP_INC) ? WIDTH'(1) : b;
      sum       = (op_in == OP_SUB) ? (a - addend) : (a + addend);
      ovf       = 1'b0;
      sc_result = '0;
      sc_flags  = flags;
      case (op_in)
         OP_ADD, OP_SUB, OP_INC: begin
            if (op_in == OP_SUB)
               ovf = (a[WIDTH-1] != addend[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            else
               ovf = (a[WIDTH-1] == addend[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            sc_result       = (SAT_EN && ovf) ? (a[WIDTH-1] ? SMIN : SMAX) : sum;
            sc_flags[FLG_Z] = (sc_result == '0);
            sc_flags[FLG_V] = ovf;
            sc_flags[FLG_N] = sc_result[WIDTH-1];
         end
         OP_NAND, OP_XOR: begin
            sc_result       = (op_in == OP_NAND) ? ~(a & b) : (a ^ b);
            sc_flags        = '0;
            sc_flags[FLG_Z] = (sc_result == '0);
         end
         default: sc_result = '0;
      endcase
   end

   always_comb begin
      state_next  = state;
      busy_next   = 1'b0;
      done_next   = 1'b0;
      result_next = result;
      flags_next  = flags;
      mul_next    = mul_q;
      load        = 1'b0;
      step        = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               case (op_in)
                  OP_SRA, OP_SRL, OP_SLL: begin
                     if (shamt == '0) begin
                        done_next   = 1'b1;
                        result_next = a;
                     end else begin
                        load       = 1'b1;
                        mul_next   = 1'b0;
                        busy_next  = 1'b1;
                        state_next = EXEC;
                     end
                  end
                  OP_MUL: begin
                     load       = 1'b1;
                     mul_next   = 1'b1;
                     busy_next  = 1'b1;
                     state_next = EXEC;
                  end
                  default: begin
                     done_next   = 1'b1;
                     result_next = sc_result;
                     flags_next  = sc_flags;
                  end
               endcase
            end
         end
         EXEC: begin
            step = 1'b1;
            if (last) begin
               state_next  = IDLE;
               done_next   = 1'b1;
               result_next = iter_value;
               if (mul_q) begin
                  flags_next        = '0;
                  flags_next[FLG_Z] = (iter_value == '0);
                  flags_next[FLG_N] = iter_value[WIDTH-1];
               end
            end else begin
               busy_next = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
         flags  <= '0;
         mul_q  <= 1'b0;
      end else begin
         state  <= state_next;
         busy   <= busy_next;
         done   <= done_next;
         result <= result_next;
         flags  <= flags_next;
         mul_q  <= mul_next;
      end
   end

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench: directed scenarios plus random ops on two instances
// (SAT_EN=0 and SAT_EN=1) compared against an arithmetic reference model.
module tb_multicycle_alu;

   localparam int unsigned W  = 16;
   localparam int unsigned SW = 4;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [3:0]    op    = '0;
   logic [W-1:0]  a     = '0;
   logic [W-1:0]  b     = '0;
   logic [SW-1:0] shamt = '0;

   logic          busy0, done0, busy1, done1;
   logic [W-1:0]  res0, res1;
   logic [2:0]    flg0, flg1;

   int errors = 0;
   int checks = 0;

   logic [2:0] ef0 = '0;
   logic [2:0] ef1 = '0;

   always #5 clk = ~clk;

   multicycle_alu #(.WIDTH(W), .SHW(SW), .SAT_EN(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .shamt(shamt),
      .busy(busy0), .done(done0), .result(res0), .flags(flg0));

   multicycle_alu #(.WIDTH(W), .SHW(SW), .SAT_EN(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .shamt(shamt),
      .busy(busy1), .done(done1), .result(res1), .flags(flg1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: signed integer arithmetic, flags as {Z,V,N}
   function automatic void model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic [SW-1:0] sh, input bit sat, input logic [2:0] pflg,
                                 output logic [W-1:0] r, output logic [2:0] f, output int lat);
      int sx, sy, s;
      bit ov;
      logic [31:0] p;
      sx  = int'($signed(x));
      sy  = int'($signed(y));
      r   = '0;
      f   = pflg;
      lat = 1;
      case (o)
         4'd0, 4'd1, 4'd4: begin
            s  = (o == 4'd0) ? sx + sy : (o == 4'd1) ? sx - sy : sx + 1;
            ov = (s > 32767) || (s < -32768);
            r  = W'(s);
            if (sat && ov) r = (sx < 0) ? 16'h8000 : 16'h7FFF;
            f  = {r == '0, ov, r[W-1]};
         end
         4'd2: begin r = ~(x & y); f = {r == '0, 2'b00}; end
         4'd3: begin r = x ^ y;    f = {r == '0, 2'b00}; end
         4'd5: begin r = $signed(x) >>> sh; lat = int'(sh) + 1; end
         4'd6: begin r = x >> sh;           lat = int'(sh) + 1; end
         4'd7: begin r = x << sh;           lat = int'(sh) + 1; end
         4'd8: begin
            p   = 32'(x) * 32'(y);
            r   = p[W-1:0];
            f   = {r == '0, 1'b0, r[W-1]};
            lat = W + 1;
         end
         default: r = '0;
      endcase
   endfunction

   // Issue one op, wait for done (bounded), check latency/busy/result/flags on both DUTs.
   // inj>0 pulses start (as an ADD) in the cycle sampled at edge T+inj.
   task automatic run_op(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [SW-1:0] sh, input int inj);
      logic [W-1:0] r0, r1;
      logic [2:0]   f0, f1;
      int lat, cyc;
      bit busy_ok;
      model(o, x, y, sh, 1'b0, ef0, r0, f0, lat);
      model(o, x, y, sh, 1'b1, ef1, r1, f1, lat);
      @(negedge clk);
      op = o; a = x; b = y; shamt = sh; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; op = 4'($urandom); a = W'($urandom); b = W'($urandom); shamt = SW'($urandom);
      cyc = 1;
      busy_ok = 1'b1;
      while (!done0 && cyc < 64) begin
         if (!busy0 || !busy1) busy_ok = 1'b0;
         if (cyc == inj) begin start = 1'b1; op = 4'd0; end
         else start = 1'b0;
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      chk({tag, ".lat"},    32'(cyc), 32'(lat));
      chk({tag, ".busy"},   32'(busy_ok), 32'd1);
      chk({tag, ".busy_d"}, 32'(busy0), 32'd0);
      chk({tag, ".done1"},  32'(done1), 32'd1);
      chk({tag, ".res0"},   32'(res0), 32'(r0));
      chk({tag, ".flg0"},   32'(flg0), 32'(f0));
      chk({tag, ".res1"},   32'(res1), 32'(r1));
      chk({tag, ".flg1"},   32'(flg1), 32'(f1));
      ef0 = f0;
      ef1 = f1;
   endtask

   function automatic logic [W-1:0] pick();
      logic [W-1:0] v;
      case ($urandom_range(0, 5))
         0: v = 16'h0000;
         1: v = 16'h7FFF;
         2: v = 16'h8000;
         3: v = 16'hFFFF;
         default: v = W'($urandom);
      endcase
      return v;
   endfunction

   initial begin
      int n;
      logic [3:0] ro;

      repeat (2) @(posedge clk);
      #1;
      chk("rst.busy", 32'(busy0), 32'd0);
      chk("rst.done", 32'(done0), 32'd0);
      chk("rst.res",  32'(res0),  32'd0);
      chk("rst.flg",  32'(flg0),  32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Overflowing ADD, wrapped vs saturated
      run_op("add_ovf", 4'd0, 16'h7FFF, 16'h0001, 4'd0, 0);
      chk("add_ovf.c0", {res0, 13'd0, flg0}, {16'h8000, 13'd0, 3'b011});
      chk("add_ovf.c1", {res1, 13'd0, flg1}, {16'h7FFF, 13'd0, 3'b010});

      // Back-to-back single-cycle ops
      run_op("sub_z",  4'd1, 16'h0005, 16'h0005, 4'd0, 0);
      chk("sub_z.c", {res0, 13'd0, flg0}, {16'h0000, 13'd0, 3'b100});
      run_op("nand_z", 4'd2, 16'hFFFF, 16'hFFFF, 4'd0, 0);
      chk("nand_z.c", {res0, 13'd0, flg0}, {16'h0000, 13'd0, 3'b100});
      run_op("xor",    4'd3, 16'h00F0, 16'h000F, 4'd0, 0);
      chk("xor.c", {res0, 13'd0, flg0}, {16'h00FF, 13'd0, 3'b000});

      // Shifts, including shamt=0 shortcut
      run_op("sra4",  4'd5, 16'h8000, 16'h1234, 4'd4, 0);
      chk("sra4.c", 32'(res0), 32'h0000F800);
      run_op("srl4",  4'd6, 16'h8000, 16'h1234, 4'd4, 0);
      chk("srl4.c", 32'(res0), 32'h00000800);
      run_op("sll15", 4'd7, 16'h0001, 16'h0000, 4'd15, 0);
      chk("sll15.c", 32'(res0), 32'h00008000);
      run_op("sra0",  4'd5, 16'hA5C3, 16'h0000, 4'd0, 0);
      chk("sra0.c", 32'(res0), 32'h0000A5C3);

      // MUL with an ignored start pulse mid-operation
      run_op("mul", 4'd8, 16'h0003, 16'hFFFF, 4'd0, 5);
      chk("mul.c", {res0, 13'd0, flg0}, {16'hFFFD, 13'd0, 3'b001});
      n = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (done0 || busy0) n++;
      end
      chk("mul.no_extra", 32'(n), 32'd0);

      // Reset during MUL aborts
      @(negedge clk);
      op = 4'd8; a = 16'h0003; b = 16'h0005; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("abort.busy", 32'(busy0), 32'd0);
      chk("abort.res",  32'(res0),  32'd0);
      chk("abort.flg",  32'(flg0),  32'd0);
      n = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (done0) n++;
      end
      chk("abort.no_done", 32'(n), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ef0 = '0;
      ef1 = '0;
      n = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (done0) n++;
      end
      chk("abort.no_late_done", 32'(n), 32'd0);
      run_op("post_rst_add", 4'd0, 16'h0010, 16'h0020, 4'd0, 0);
      chk("post_rst_add.c", 32'(res0), 32'h00000030);

      // Illegal op keeps flags from a flag-setting SUB
      run_op("sub_ovf", 4'd1, 16'h8000, 16'h0001, 4'd0, 0);
      run_op("illegal", 4'd12, 16'h1234, 16'h5678, 4'd3, 0);
      chk("illegal.c", {res0, 13'd0, flg0}, {16'h0000, 13'd0, 3'b010});

      // Random traffic
      for (int i = 0; i < 40; i++) begin
         ro = ($urandom_range(0, 4) == 0) ? 4'd8 : 4'($urandom_range(0, 15));
         run_op("rnd", ro, pick(), pick(), SW'($urandom), 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
